usb_buf_sched: RTL
==================

USB_BUF_SCHED -- requirements
Module: usb_buf_sched

Interface
REQ-001 Parameter TMO_NBIT, default 12: width of the write-grant watchdog counter; timeout occurs after 2^TMO_NBIT-1 cycles.
REQ-002 mclk  in  1  main clock, 48 MHz; all logic on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_req  in  1  level; command responder has a response frame to write.
REQ-005 adc_req  in  1  level; ADC frame packer has a data frame to write.
REQ-006 cmd_gnt  out  1  command responder owns the TX buffer write port.
REQ-007 adc_gnt  out  1  ADC packer owns the TX buffer write port.
REQ-008 wr_eop  in  1  one-cycle pulse from the granted writer; frame complete.
REQ-009 wr_baddr  out  2  base address the granted writer shall use.
REQ-010 acq_en  in  1  acquisition enable from command decode.
REQ-011 rd_vld  out  1  a full buffer is ready for USB drain.
REQ-012 rd_baddr  out  2  base address of the buffer to drain; valid while rd_vld=1.
REQ-013 rd_done  in  1  one-cycle pulse; USB side finished draining rd_baddr.
REQ-014 adc_ovf  out  1  sticky; ADC frame requested while its target buffer was full.
REQ-015 wr_tmo  out  1  one-cycle pulse; grant aborted by the watchdog.

Function
REQ-016 Regions: 2'b00 handshake, 2'b10 ping, 2'b11 pong; 2'b01 is never issued; each region has a FREE/FULL flag.
REQ-017 Arbiter FSM states: IDLE, GNT_CMD, GNT_ADC.
REQ-018 IDLE -> GNT_CMD when cmd_req=1 and region 00 is FREE; command has fixed priority over ADC.
REQ-019 IDLE -> GNT_ADC when GNT_CMD is not taken, adc_req=1, acq_en=1 and the ADC target region (ping/pong pointer) is FREE.
REQ-020 cmd_gnt and adc_gnt are registered, asserted on the cycle after the IDLE transition, never both high, held until exit.
REQ-021 wr_baddr = 00 in GNT_CMD, the pointer value in GNT_ADC, 00 in IDLE.
REQ-022 wr_eop in GNT_x: mark wr_baddr FULL, push it into the ready queue, return to IDLE (grant drops the next cycle); in GNT_ADC also toggle the pointer 10<->11.
REQ-023 wr_eop in IDLE is ignored.
REQ-024 Watchdog: clears on entry to GNT_x and counts each cycle in GNT_x; at all-ones without wr_eop, return to IDLE, pulse wr_tmo, leave the region FREE, and do not toggle the pointer.
REQ-025 Ready queue: FIFO, depth 3, 2-bit entries, order of completion preserved; rd_vld = queue not empty; rd_baddr = head.
REQ-026 rd_done with rd_vld=1 pops the head and marks that region FREE; rd_done with rd_vld=0 is ignored.
REQ-027 Push and pop in the same cycle both take effect; a region freed by rd_done becomes grantable on the next cycle.
REQ-028 The queue cannot overflow because each region is enqueued at most once while FULL.
REQ-029 Pointer resets to 10 while acq_en=0 and the FSM is not in GNT_ADC.
REQ-030 adc_ovf sets when in IDLE with adc_req=1, acq_en=1, target FULL and no command grant taken.
REQ-031 adc_ovf clears on the cycle after a rising edge of acq_en.
REQ-032 acq_en falling during GNT_ADC does not abort the grant; the frame completes normally.
REQ-033 Grant-to-first-write latency: 1 cycle from request sampled in IDLE; minimum request-to-request turnaround: 2 cycles.

Reset
REQ-034 rst_n=0 asynchronously forces: FSM IDLE, cmd_gnt=0, adc_gnt=0, wr_baddr=00, all regions FREE, queue empty, rd_vld=0, rd_baddr=00, pointer=10, adc_ovf=0, wr_tmo=0, watchdog=0.
REQ-035 Reset asserted mid-grant or mid-drain discards all state; no wr_tmo pulse is produced by reset.
REQ-036 The first grant may occur on the second rising mclk edge after rst_n deasserts.

Verification
REQ-037 cmd_req and adc_req rise together in IDLE, acq_en=1 -> cmd_gnt=1, wr_baddr=00; after wr_eop, adc_gnt=1, wr_baddr=10.
REQ-038 Three ADC frames, acq_en=1, no rd_done -> baddr 10 then 11 granted; the third request gives no grant and adc_ovf=1; rd_done frees 10, then the third grant uses 10.
REQ-039 Frames completed in order 10, 00, 11 -> rd_baddr sequence 10, 00, 11 across three rd_done pulses, then rd_vld=0.
REQ-040 TMO_NBIT=4, grant held without wr_eop -> after 15 cycles wr_tmo pulses, grant drops, region stays FREE, pointer unchanged.
REQ-041 wr_eop and rd_done on the same cycle with queue holding 1 entry -> queue count stays 1, head advances, freed region regrantable the next cycle.
REQ-042 rst_n low for 1 cycle during GNT_ADC with 2 queued entries -> all outputs at reset values immediately, pointer=10, rd_vld=0.

Source files
------------

// File: rtl/usb_buf_sched.sv
`default_nettype none
// ============================================================================
// Module   : usb_buf_sched
// Brief    : TX buffer write arbiter (command vs. ADC) with ping/pong regions,
//            ready FIFO for USB drain, overflow flag and grant watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module usb_buf_sched #(
  parameter int TMO_NBIT = 12
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       cmd_req,
  input  logic       adc_req,
  output logic       cmd_gnt,
  output logic       adc_gnt,
  input  logic       wr_eop,
  output logic [1:0] wr_baddr,
  input  logic       acq_en,
  output logic       rd_vld,
  output logic [1:0] rd_baddr,
  input  logic       rd_done,
  output logic       adc_ovf,
  output logic       wr_tmo
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_CMD = 2'd1,
    ST_GNT_ADC = 2'd2
  } state_t;

  localparam logic [1:0]          C_HS_ADDR  = 2'b00;
  localparam logic [TMO_NBIT-1:0] C_WDOG_MAX = '1;

  state_t              r_state;
  logic [3:0]          r_full;
  logic                r_ptr;      // 0 selects ping (10), 1 selects pong (11)
  logic [TMO_NBIT-1:0] r_wdog;
  logic [1:0]          r_q [3];
  logic [1:0]          r_head;
  logic [1:0]          r_cnt;
  logic                r_acq_d;

  logic [1:0]          w_tgt;
  logic                w_cmd_ok;
  logic                w_adc_want;
  logic                w_adc_ok;
  logic                w_ovf_set;
  logic                w_push;
  logic                w_pop;
  logic [TMO_NBIT-1:0] w_wdog_nxt;
  logic                w_tmo_hit;
  logic [2:0]          w_sum;
  logic [1:0]          w_tail;
  logic [1:0]          w_head_nxt;

  always_comb begin
    w_tgt      = {1'b1, r_ptr};
    w_cmd_ok   = (r_state == ST_IDLE) && cmd_req && !r_full[C_HS_ADDR];
    w_adc_want = (r_state == ST_IDLE) && !w_cmd_ok && adc_req && acq_en;
    w_adc_ok   = w_adc_want && !r_full[w_tgt];
    w_ovf_set  = w_adc_want && r_full[w_tgt];
    w_push     = (r_state != ST_IDLE) && wr_eop;
    w_pop      = rd_done && rd_vld;
    // Grant lasts 2^TMO_NBIT-1 cycles: abort when the count is about to reach all-ones
    w_wdog_nxt = r_wdog + 1'b1;
    w_tmo_hit  = (r_state != ST_IDLE) && !wr_eop && (w_wdog_nxt == C_WDOG_MAX);
    w_sum      = {1'b0, r_head} + {1'b0, r_cnt};
    w_tail     = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
    w_head_nxt = (r_head == 2'd2) ? 2'd0 : r_head + 2'd1;
  end

  assign rd_vld   = (r_cnt != 2'd0);
  assign rd_baddr = rd_vld ? r_q[r_head] : 2'b00;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      cmd_gnt  <= 1'b0;
      adc_gnt  <= 1'b0;
      wr_baddr <= 2'b00;
      r_full   <= 4'b0000;
      r_ptr    <= 1'b0;
      r_wdog   <= '0;
      r_q      <= '{default: 2'b00};
      r_head   <= 2'd0;
      r_cnt    <= 2'd0;
      r_acq_d  <= 1'b0;
      adc_ovf  <= 1'b0;
      wr_tmo   <= 1'b0;
    end else begin
      wr_tmo  <= 1'b0;
      r_acq_d <= acq_en;

      if (w_ovf_set)
        adc_ovf <= 1'b1;
      else if (acq_en && !r_acq_d)
        adc_ovf <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_cmd_ok) begin
            r_state  <= ST_GNT_CMD;
            cmd_gnt  <= 1'b1;
            wr_baddr <= C_HS_ADDR;
            r_wdog   <= '0;
          end else if (w_adc_ok) begin
            r_state  <= ST_GNT_ADC;
            adc_gnt  <= 1'b1;
            wr_baddr <= w_tgt;
            r_wdog   <= '0;
          end
        end
        ST_GNT_CMD, ST_GNT_ADC: begin
          if (wr_eop || w_tmo_hit) begin
            r_state  <= ST_IDLE;
            cmd_gnt  <= 1'b0;
            adc_gnt  <= 1'b0;
            wr_baddr <= 2'b00;
            wr_tmo   <= !wr_eop;
            if (wr_eop && (r_state == ST_GNT_ADC))
              r_ptr <= ~r_ptr;
          end else begin
            r_wdog <= w_wdog_nxt;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          cmd_gnt  <= 1'b0;
          adc_gnt  <= 1'b0;
          wr_baddr <= 2'b00;
        end
      endcase

      if ((r_state != ST_GNT_ADC) && !acq_en)
        r_ptr <= 1'b0;

      // Pushed and popped regions always differ: a writer only owns a FREE region
      if (w_push) begin
        r_full[wr_baddr] <= 1'b1;
        r_q[w_tail]      <= wr_baddr;
      end
      if (w_pop) begin
        r_full[rd_baddr] <= 1'b0;
        r_head           <= w_head_nxt;
      end

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire
